// File: rtl/aurora_chk_pkg.sv
// Shared definitions for the aurora_chk test path: fill pattern, sequence width, generator FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package aurora_chk_pkg;

    // Sequence field width; the far-end checker compares exactly this many LSBs.
    localparam int SEQ_WD = 16;

    // Fill pattern placed above the sequence number; resized to DATA_WD-SEQ_WD by the user.
    localparam logic [47:0] PAT = 48'hBBBB_CCCC_DDDD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } gen_state_t;

endpackage

// File: rtl/aurora_gen_cnt.sv
// Wrapping event counter with synchronous clear, used for link statistics.
// Latency: count reflects an event on the cycle after it is sampled.
// Backpressure: none; counts every cycle inc is high.
//
// Ports: clk, rst_n (sync, active-low), clr (sync, active-high), inc (event), cnt (running count).
module aurora_gen_cnt #(
    parameter int WDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            inc,
    output logic [WDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/aurora_20g_enc_gen.sv
// Aurora test-pattern generator: emits {PAT, seq} beats in programmable bursts with inter-burst gaps.
// Latency: enc_vld rises the cycle after an accepted cfg_start.
// Backpressure: enc_vld/enc_data hold while tx_ready is low; each such cycle bumps stall_cnt.
//
// Ports: clk, rst_n (sync, active-low), cfg_rst (soft clear), cfg_start/cfg_stop (pulses),
//        cfg_burst_len/cfg_gap_len/cfg_burst_num (latched at start), tx_ready (downstream),
//        enc_vld/enc_data (beat out), busy, sent_cnt, stall_cnt.
// Optional: define AURORA_ENC_GEN_ERR_INJ_EN to add cfg_err_inj, which flips seq bit 0 on one beat.
module aurora_20g_enc_gen
    import aurora_chk_pkg::*;
#(
    parameter int DATA_WD = 64,
    parameter int SEQ_WD  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_rst,
    input  logic               cfg_start,
    input  logic               cfg_stop,
    input  logic [15:0]        cfg_burst_len,
    input  logic [15:0]        cfg_gap_len,
    input  logic [15:0]        cfg_burst_num,
`ifdef AURORA_ENC_GEN_ERR_INJ_EN
    input  logic               cfg_err_inj,
`endif
    input  logic               tx_ready,
    output logic               enc_vld,
    output logic [DATA_WD-1:0] enc_data,
    output logic               busy,
    output logic [31:0]        sent_cnt,
    output logic [31:0]        stall_cnt
);

    gen_state_t        state;
    logic [SEQ_WD-1:0] seq;
    logic [15:0]       len_q;
    logic [15:0]       gap_q;
    logic [15:0]       num_q;
    logic [15:0]       beat_cnt;
    logic [15:0]       burst_cnt;
    logic [15:0]       gap_cnt;
    logic              stop_pend;
    logic              inj_act;

    logic xfer;
    logic stall;
    logic last_beat;
    logic last_burst;

    assign xfer       = enc_vld && tx_ready;
    assign stall      = enc_vld && !tx_ready;
    assign last_beat  = (beat_cnt == len_q - 16'd1);
    assign last_burst = (num_q != 16'd0) && (burst_cnt == num_q - 16'd1);
    assign busy       = (state != IDLE);

    // Low bits of {PAT, 0} give the pattern truncated in its MSBs (or zero-extended when wider).
    logic [DATA_WD-1:0] pat_full;
    logic [SEQ_WD-1:0]  seq_tx;

    assign pat_full = DATA_WD'({PAT, {SEQ_WD{1'b0}}});
    assign seq_tx   = seq ^ {{(SEQ_WD-1){1'b0}}, inj_act};
    // seq only moves on a transfer, so the payload is stable for the whole life of a beat.
    assign enc_data = enc_vld ? (pat_full | DATA_WD'(seq_tx)) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n || cfg_rst) begin
            state     <= IDLE;
            enc_vld   <= 1'b0;
            seq       <= '0;
            len_q     <= 16'd1;
            gap_q     <= '0;
            num_q     <= '0;
            beat_cnt  <= '0;
            burst_cnt <= '0;
            gap_cnt   <= '0;
            stop_pend <= 1'b0;
        end else begin
            if (xfer) begin
                seq <= seq + 1'b1;
            end
            case (state)
                IDLE: begin
                    enc_vld   <= 1'b0;
                    stop_pend <= 1'b0;
                    if (cfg_start && !cfg_stop) begin
                        len_q     <= (cfg_burst_len == 16'd0) ? 16'd1 : cfg_burst_len;
                        gap_q     <= cfg_gap_len;
                        num_q     <= cfg_burst_num;
                        beat_cnt  <= '0;
                        burst_cnt <= '0;
                        state     <= SEND;
                        enc_vld   <= 1'b1;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (last_beat) begin
                            burst_cnt <= burst_cnt + 16'd1;
                            beat_cnt  <= '0;
                            if (last_burst || stop_pend || cfg_stop) begin
                                state     <= IDLE;
                                enc_vld   <= 1'b0;
                                stop_pend <= 1'b0;
                            end else if (gap_q != 16'd0) begin
                                state   <= GAP;
                                enc_vld <= 1'b0;
                                gap_cnt <= '0;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 16'd1;
                            if (stop_pend || cfg_stop) begin
                                state     <= IDLE;
                                enc_vld   <= 1'b0;
                                stop_pend <= 1'b0;
                            end
                        end
                    end else if (cfg_stop) begin
                        // Beat is outstanding: remember the stop and let the beat finish.
                        stop_pend <= 1'b1;
                    end
                end
                GAP: begin
                    if (cfg_stop) begin
                        state <= IDLE;
                    end else if (gap_cnt == gap_q - 16'd1) begin
                        state   <= SEND;
                        enc_vld <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    enc_vld <= 1'b0;
                end
            endcase
        end
    end

`ifdef AURORA_ENC_GEN_ERR_INJ_EN
    // err_arm remembers a request; inj_act is the flag bound to the beat on the wire.
    // inj_act only reloads when a fresh beat is about to be presented, so a request
    // arriving mid-stall never disturbs the held payload.
    logic err_arm;
    logic inj_load;
    logic arm_nxt;

    assign inj_load = !stall;
    assign arm_nxt  = (err_arm && !(xfer && inj_act)) || cfg_err_inj;

    always_ff @(posedge clk) begin
        if (!rst_n || cfg_rst) begin
            err_arm <= 1'b0;
            inj_act <= 1'b0;
        end else begin
            err_arm <= arm_nxt;
            if (inj_load) begin
                inj_act <= arm_nxt;
            end
        end
    end
`else
    assign inj_act = 1'b0;
`endif

    aurora_gen_cnt #(.WDTH(32)) u_sent_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cfg_rst),
        .inc   (xfer),
        .cnt   (sent_cnt)
    );

    aurora_gen_cnt #(.WDTH(32)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cfg_rst),
        .inc   (stall),
        .cnt   (stall_cnt)
    );

endmodule
